// File: rtl/counter_1hz.sv
// Clock divider producing a registered OUT_HZ square wave plus its phase count.
// Optional macro COUNTER_1HZ_TICK_EN adds a one-cycle tick output on each period wrap.
module counter_1hz #(
    parameter int CLK_HZ = 100,
    parameter int OUT_HZ = 1,
    parameter int DIVIDE = CLK_HZ / OUT_HZ,
    parameter int CW     = (DIVIDE > 2) ? $clog2(DIVIDE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic          out,
    output logic [CW-1:0] phase
`ifdef COUNTER_1HZ_TICK_EN
    ,
    output logic          tick
`endif
);

    // A divider below 2 or a non-integer ratio cannot produce a square wave.
    generate
        if (DIVIDE < 2 || (CLK_HZ % OUT_HZ) != 0) begin : g_bad_divide
            $error("counter_1hz: DIVIDE must be an integer >= 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);
    localparam logic [CW-1:0] HALF = CW'(DIVIDE / 2);

    logic [CW-1:0] phase_next;
    logic          wrap;

    always_comb begin
        wrap       = (phase == LAST);
        phase_next = wrap ? '0 : phase + 1'b1;
    end

    // out is derived from the upcoming phase so it stays a pure register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            out   <= 1'b0;
        end else if (clr) begin
            phase <= '0;
            out   <= 1'b0;
        end else if (en) begin
            phase <= phase_next;
            out   <= (phase_next >= HALF);
        end
    end

`ifdef COUNTER_1HZ_TICK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else if (clr) begin
            tick <= 1'b0;
        end else begin
            tick <= en && wrap;
        end
    end
`endif

endmodule

// File: tb/tb_counter_1hz.sv
// Bench for counter_1hz: default (DIVIDE=100) and DIVIDE=7 instances driven together,
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_counter_1hz;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       out100;
    logic [6:0] phase100;
    logic       out7;
    logic [2:0] phase7;
    logic       tick100;
    logic       tick7;

    int checks   = 0;
    int failures = 0;

    int cnt[2];
    int mtick[2];
    int div[2] = '{100, 7};
    int tick_count = 0;

    always #5 clk = ~clk;

    counter_1hz u100 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .out   (out100),
        .phase (phase100)
`ifdef COUNTER_1HZ_TICK_EN
        ,
        .tick  (tick100)
`endif
    );

    counter_1hz #(.CLK_HZ(7), .OUT_HZ(1)) u7 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .out   (out7),
        .phase (phase7)
`ifdef COUNTER_1HZ_TICK_EN
        ,
        .tick  (tick7)
`endif
    );

`ifndef COUNTER_1HZ_TICK_EN
    assign tick100 = 1'b0;
    assign tick7   = 1'b0;
`endif

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Each call holds the given inputs for n rising edges and returns on a falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic c, input int n);
        #1;
        rst = r;
        en  = e;
        clr = c;
        repeat (n) @(negedge clk);
    endtask

    // Model: phase is the count of enabled edges since reset/clear, modulo the divider.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || clr) begin
                cnt[k]   = 0;
                mtick[k] = 0;
            end else if (en) begin
                mtick[k] = (cnt[k] == div[k] - 1) ? 1 : 0;
                cnt[k]   = (cnt[k] + 1) % div[k];
            end else begin
                mtick[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_phase100", int'(phase100), cnt[0]);
        checkOutput("model_out100", int'(out100), (cnt[0] >= div[0] / 2) ? 1 : 0);
        checkOutput("model_phase7", int'(phase7), cnt[1]);
        checkOutput("model_out7", int'(out7), (cnt[1] >= div[1] / 2) ? 1 : 0);
`ifdef COUNTER_1HZ_TICK_EN
        checkOutput("model_tick100", int'(tick100), mtick[0]);
        checkOutput("model_tick7", int'(tick7), mtick[1]);
`endif
    end

    always @(posedge clk) begin
        #1;
        if (tick100) tick_count++;
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;

        applyStimulus(1, 0, 0, 2);
        checkOutput("reset_phase100", int'(phase100), 0);
        checkOutput("reset_out100", int'(out100), 0);
        checkOutput("reset_phase7", int'(phase7), 0);
        checkOutput("reset_tick100", int'(tick100), 0);

        applyStimulus(0, 1, 0, 49);
        checkOutput("edge49_out100", int'(out100), 0);
        checkOutput("edge49_phase100", int'(phase100), 49);
        checkOutput("edge49_phase7", int'(phase7), 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("edge50_out100", int'(out100), 1);
        checkOutput("edge50_phase100", int'(phase100), 50);
        applyStimulus(0, 1, 0, 50);
        checkOutput("edge100_out100", int'(out100), 0);
        checkOutput("edge100_phase100", int'(phase100), 0);
        checkOutput("edge100_phase7", int'(phase7), 2);
`ifdef COUNTER_1HZ_TICK_EN
        checkOutput("edge100_tick100", int'(tick100), 1);
`endif
        applyStimulus(0, 1, 0, 100);
        checkOutput("edge200_out100", int'(out100), 0);
        checkOutput("edge200_out7", int'(out7), 1);
        applyStimulus(0, 1, 0, 100);
        checkOutput("edge300_phase100", int'(phase100), 0);
`ifdef COUNTER_1HZ_TICK_EN
        checkOutput("tick_count_300", tick_count, 3);
`endif

        applyStimulus(0, 1, 0, 73);
        checkOutput("edge373_phase100", int'(phase100), 73);
        checkOutput("edge373_out100", int'(out100), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_phase100", int'(phase100), 0);
        checkOutput("async_rst_out100", int'(out100), 0);
        checkOutput("async_rst_phase7", int'(phase7), 0);
        @(negedge clk);
        applyStimulus(0, 1, 0, 49);
        checkOutput("post_rst_49_out100", int'(out100), 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("post_rst_50_out100", int'(out100), 1);

        applyStimulus(0, 1, 0, 10);
        checkOutput("pre_clr_phase100", int'(phase100), 60);
        applyStimulus(0, 1, 1, 1);
        checkOutput("clr_en_phase100", int'(phase100), 0);
        checkOutput("clr_en_out100", int'(out100), 0);
        checkOutput("clr_en_tick100", int'(tick100), 0);
        applyStimulus(0, 1, 0, 3);
        checkOutput("d7_edge3_out7", int'(out7), 1);
        checkOutput("d7_edge3_phase7", int'(phase7), 3);
        applyStimulus(0, 1, 0, 17);
        checkOutput("pre_freeze_phase100", int'(phase100), 20);
        checkOutput("pre_freeze_phase7", int'(phase7), 6);
        applyStimulus(0, 0, 0, 30);
        checkOutput("freeze_phase100", int'(phase100), 20);
        checkOutput("freeze_out100", int'(out100), 0);
        checkOutput("freeze_phase7", int'(phase7), 6);
        applyStimulus(0, 1, 0, 29);
        checkOutput("resume29_out100", int'(out100), 0);
        checkOutput("resume29_phase7", int'(phase7), 0);
        checkOutput("resume29_out7", int'(out7), 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("resume30_out100", int'(out100), 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("clr_noen_phase100", int'(phase100), 0);
        checkOutput("clr_noen_out100", int'(out100), 0);
        applyStimulus(0, 1, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_1hz.md
Name: counter_1hz

Overview:
- Free-running clock divider that derives a 1 Hz square wave from the system clock, which is 100 Hz by default.
- Timebase for the microwave controller's timer-input path; downstream logic counts seconds on its edges or on its tick pulse.
- Adds an enable, a synchronous clear, an exposed phase count and an optional one-cycle tick.

Parameters:
- CLK_HZ, 100: input clock frequency in Hz.
- OUT_HZ, 1: output frequency in Hz.
- DIVIDE, CLK_HZ/OUT_HZ: clock cycles per output period; must be integer and >=2, otherwise elaboration error ($error/$fatal).
- CW, $clog2(DIVIDE): phase counter width, minimum 1.

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: count enable; 0 freezes counter and output.
- clr, input, 1: synchronous clear; returns to the reset state on the next edge.
- out, input-derived output, 1: 1 Hz square wave, registered.
- phase, output, CW: current phase count, 0..DIVIDE-1.
- tick, output, 1: only present with COUNTER_1HZ_TICK_EN (see Optional Feature).

Behaviour:
- Reset (rst=1, asynchronous, immediate): phase=0, out=0, tick=0. Held while rst=1.
- Priority per rising edge: rst > clr > en.
- clr=1: phase<=0, out<=0, tick<=0, regardless of en.
- en=1, clr=0:
  - phase<=phase+1, except at DIVIDE-1 it wraps to 0.
  - out<=(phase_next >= DIVIDE/2), using integer division.
  - out is therefore low for DIVIDE/2 cycles, then high for DIVIDE-DIVIDE/2 cycles. Odd DIVIDE gives the extra cycle to the high phase.
- en=0, clr=0: phase and out hold; tick<=0.
- Edge timing with defaults, counting enabled edges after reset release:
  - out rises on the 50th edge (phase=50).
  - out falls on the 100th edge (phase wraps to 0).
  - Period is exactly 100 clocks (1000 ms); duty is 50%.
- out is a pure register output, with no combinational path from the inputs.
- Counter never exceeds DIVIDE-1.
- Reset asserted mid-period aborts the period; the next period starts from phase 0 after release.
- Deasserting en mid-period resumes from the frozen phase; no cycles are lost or added.
- Simultaneous clr and en: clr wins.
- With DIVIDE=2, out toggles on every enabled edge.

Optional Feature:
- Macro: COUNTER_1HZ_TICK_EN.
- When defined:
  - Output port tick (1 bit) exists.
  - tick<=1 on the enabled edge where phase wraps DIVIDE-1 -> 0, otherwise tick<=0.
  - tick is high for exactly one clk cycle per period, coincident with the falling edge of out.
  - Reset/clr force tick=0.
- When undefined: the tick port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults, rst pulse then en=1 held for 200 clocks (2000 ms at 10 ms period) -> out=0 for clocks 1-49, out=1 at edge 50, out=0 at edge 100, out=1 at edge 150, out=0 at edge 200; phase sequence 0..99 wraps cleanly.
- rst asserted asynchronously mid-cycle at phase=73 -> phase=0 and out=0 immediately, without waiting for a clk edge; after release, first out rise comes 50 edges later.
- en=0 for 30 clocks starting at phase=20 -> phase stays 20, out stays 0; after en=1, out rises after 30 more edges.
- clr=1 together with en=1 at phase=60 (out=1) -> next edge gives phase=0, out=0; tick stays 0 when the macro is defined.
- COUNTER_1HZ_TICK_EN defined, 300 enabled clocks -> exactly 3 tick pulses, each 1 cycle wide, at edges 100, 200 and 300, each aligned with an out falling edge.
- Parameter override CLK_HZ=7, OUT_HZ=1 (DIVIDE=7) -> out low for 3 cycles, high for 4, period 7 clocks; CW=3.
